banked_two_port_ram: RTL

- Parametrised successor to the single-bank sequencer two-port RAM.
- Provides NBANK independent simple-dual-port banks, each with one write port and one read port, sharing a single clock.
- Adds read enable, a read-valid pipeline, selectable read-during-write collision mode and an asynchronous active-low reset on the control and output pipeline.
- Used by the VP sequencer and lane buffers wherever several coefficient lanes need lock-step storage with a fixed, tagged read latency.

---
 rtl/banked_two_port_ram.sv | 111 +++++++++++
 1 files changed

// File: rtl/banked_two_port_ram.sv
// NBANK independent simple-dual-port RAM banks with a fixed-latency, valid-tagged
// read pipeline, selectable read-during-write policy and a saturating collision counter.
module banked_two_port_ram #(
  parameter int DWIDTH            = 16,
  parameter int DEPTH             = 8,
  parameter int AWIDTH            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NBANK             = 4,
  parameter int COMMON_BRAM_DELAY = 2,
  parameter int WR_MODE           = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NBANK-1:0]         wea,
  input  logic [NBANK*AWIDTH-1:0]  addra,
  input  logic [NBANK*DWIDTH-1:0]  dina,
  input  logic [NBANK-1:0]         reb,
  input  logic [NBANK*AWIDTH-1:0]  addrb,
  output logic [NBANK*DWIDTH-1:0]  doutb,
  output logic [NBANK-1:0]         doutb_vld,
  output logic [15:0]              coll_cnt
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [AWIDTH:0] DEPTH_W = DEPTH[AWIDTH:0];

  logic [NBANK-1:0] coll;
  logic [15:0]      coll_cnt_q;
  logic [15:0]      coll_cnt_d;
  logic [16:0]      coll_sum;
  logic [16:0]      coll_inc;

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    logic [AWIDTH-1:0]            wr_addr;
    logic [AWIDTH-1:0]            rd_addr;
    logic [DWIDTH-1:0]            wr_data;
    logic                         wr_ok;
    logic                         rd_ok;
    logic [DWIDTH-1:0]            rd_word;
    logic [DWIDTH-1:0]            mem_q [DEPTH];
    logic [COMMON_BRAM_DELAY-1:0] vld_q;
    logic [DWIDTH-1:0]            data_q [COMMON_BRAM_DELAY];

    assign wr_addr = addra[i*AWIDTH +: AWIDTH];
    assign rd_addr = addrb[i*AWIDTH +: AWIDTH];
    assign wr_data = dina[i*DWIDTH +: DWIDTH];
    assign wr_ok   = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok   = ({1'b0, rd_addr} < DEPTH_W);
    assign coll[i] = wea[i] & reb[i] & (wr_addr == rd_addr);

    // mem_q is read before the edge commits, so read-first falls out naturally;
    // write-first bypasses the incoming word.
    always_comb begin
      rd_word = '0;
      if (rd_ok) begin
        if ((WR_MODE != 0) && coll[i]) begin
          rd_word = wr_data;
        end else begin
          rd_word = mem_q[rd_addr];
        end
      end
    end

    // Storage is deliberately not reset; rst_n only blocks writes while asserted.
    always_ff @(posedge clk) begin
      if (rst_n && wea[i] && wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int k = 0; k < COMMON_BRAM_DELAY; k++) begin
          data_q[k] <= '0;
        end
      end else begin
        vld_q[0] <= reb[i];
        if (reb[i]) begin
          data_q[0] <= rd_word;
        end
        for (int k = 1; k < COMMON_BRAM_DELAY; k++) begin
          vld_q[k]  <= vld_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end

    assign doutb[i*DWIDTH +: DWIDTH] = data_q[COMMON_BRAM_DELAY-1];
    assign doutb_vld[i]              = vld_q[COMMON_BRAM_DELAY-1];
  end

  always_comb begin
    coll_inc = '0;
    for (int i = 0; i < NBANK; i++) begin
      coll_inc = coll_inc + {16'd0, coll[i]};
    end
    coll_sum   = {1'b0, coll_cnt_q} + coll_inc;
    coll_cnt_d = coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt_q <= '0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign coll_cnt = coll_cnt_q;

endmodule
